// File: rtl/accum_step_fifo.sv
// Step-value FIFO feeding a 4-bit up accumulator: buffers producer steps and
// emits exactly one step (or a zero no-op) per cycle, with occupancy and overflow status.
module accum_step_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic             pop_en,
    output logic [WIDTH-1:0] step,
    output logic             step_valid,
    output logic [AW:0]      level,
    output logic             full,
    output logic             empty,
    output logic             ovf,
    input  logic             ovf_clr
);

    localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0] LVL_FULL = {1'b1, {AW{1'b0}}};

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wp;
    logic [AW:0]      r_rp;
    logic [WIDTH-1:0] r_step;
    logic             r_step_valid;
    logic             r_ovf;

    logic [AW:0]      w_level;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;

    // Pointers carry a wrap bit, so full and empty differ only in that bit.
    assign w_level = r_wp - r_rp;
    assign w_full  = (w_level == LVL_FULL);
    assign w_empty = (w_level == '0);
    assign w_push  = in_valid && !w_full;
    assign w_pop   = pop_en && !w_empty;

    assign in_ready   = !w_full;
    assign level      = w_level;
    assign full       = w_full;
    assign empty      = w_empty;
    assign step       = r_step;
    assign step_valid = r_step_valid;
    assign ovf        = r_ovf;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wp[AW-1:0]] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            r_wp         <= '0;
            r_rp         <= '0;
            r_step       <= '0;
            r_step_valid <= 1'b0;
            r_ovf        <= 1'b0;
        end else begin
            if (w_push) begin
                r_wp <= r_wp + PTR_ONE;
            end
            // Idle cycles present zero so the accumulator's add becomes a no-op.
            if (w_pop) begin
                r_step       <= r_mem[r_rp[AW-1:0]];
                r_step_valid <= 1'b1;
                r_rp         <= r_rp + PTR_ONE;
            end else begin
                r_step       <= '0;
                r_step_valid <= 1'b0;
            end
            if (in_valid && w_full) begin
                r_ovf <= 1'b1;
            end else if (ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_accum_step_fifo.sv
// Self-checking bench for accum_step_fifo: queue-based reference model compared
// every cycle, plus directed sequences with hand-computed expectations.
module tb_accum_step_fifo;

    localparam int WIDTH = 4;
    localparam int DEPTH = 4;

    logic       clk;
    logic       clear_n;
    logic       inValid;
    logic [3:0] inData;
    logic       inReady;
    logic       popEn;
    logic [3:0] step;
    logic       stepValid;
    logic [2:0] level;
    logic       full;
    logic       empty;
    logic       ovf;
    logic       ovfClr;

    int checks = 0;
    int errors = 0;
    bit compareOn = 0;

    logic [3:0] modelQ[$];
    logic [3:0] mStep;
    logic       mValid;
    logic       mOvf;
    logic [3:0] accSum;

    accum_step_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .clear_n    (clear_n),
        .in_valid   (inValid),
        .in_data    (inData),
        .in_ready   (inReady),
        .pop_en     (popEn),
        .step       (step),
        .step_valid (stepValid),
        .level      (level),
        .full       (full),
        .empty      (empty),
        .ovf        (ovf),
        .ovf_clr    (ovfClr)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // Reference model: a plain queue holding at most DEPTH steps.
    always @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            modelQ.delete();
            mStep  = 0;
            mValid = 0;
            mOvf   = 0;
        end else begin
            int sz;
            sz = modelQ.size();
            if (popEn && sz > 0) begin
                mStep  = modelQ.pop_front();
                mValid = 1;
            end else begin
                mStep  = 0;
                mValid = 0;
            end
            if (inValid && sz < DEPTH) modelQ.push_back(inData);
            if (inValid && sz == DEPTH) mOvf = 1;
            else if (ovfClr) mOvf = 0;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    always @(negedge clk) begin
        if (compareOn) begin
            checkOutput("cmp_step", {28'd0, step}, {28'd0, mStep});
            checkOutput("cmp_step_valid", {31'd0, stepValid}, {31'd0, mValid});
            checkOutput("cmp_level", {29'd0, level}, modelQ.size());
            checkOutput("cmp_full", {31'd0, full}, {31'd0, modelQ.size() == DEPTH});
            checkOutput("cmp_empty", {31'd0, empty}, {31'd0, modelQ.size() == 0});
            checkOutput("cmp_in_ready", {31'd0, inReady}, {31'd0, modelQ.size() != DEPTH});
            checkOutput("cmp_ovf", {31'd0, ovf}, {31'd0, mOvf});
        end
    end

    task automatic applyStimulus(input logic v, input logic [3:0] d, input logic p, input logic c);
        inValid = v;
        inData  = d;
        popEn   = p;
        ovfClr  = c;
        @(posedge clk);
        #1;
    endtask

    task automatic checkPop(input string name, input logic [3:0] s, input logic sv, input logic [2:0] lv);
        checkOutput({name, "_step"}, {28'd0, step}, {28'd0, s});
        checkOutput({name, "_valid"}, {31'd0, stepValid}, {31'd0, sv});
        checkOutput({name, "_level"}, {29'd0, level}, {29'd0, lv});
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish within bound");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        clear_n = 0;
        inValid = 0;
        inData  = 0;
        popEn   = 0;
        ovfClr  = 0;
        accSum  = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        clear_n = 1;
        compareOn = 1;

        // Reset mid-stream with ovf set and three entries stored.
        for (int i = 0; i < 4; i++) applyStimulus(1, 4'(i + 10), 0, 0);
        applyStimulus(1, 4'hE, 0, 0);
        applyStimulus(0, 0, 1, 0);
        checkPop("pre_reset", 4'hA, 1, 3);
        checkOutput("pre_reset_ovf", {31'd0, ovf}, 1);
        inValid = 0;
        popEn   = 0;
        clear_n = 0;
        #2;
        checkPop("reset", 0, 0, 0);
        checkOutput("reset_empty", {31'd0, empty}, 1);
        checkOutput("reset_in_ready", {31'd0, inReady}, 1);
        checkOutput("reset_ovf", {31'd0, ovf}, 0);
        @(negedge clk);
        clear_n = 1;

        // Ordered pass-through into a modelled 4-bit accumulator.
        applyStimulus(1, 4'h3, 1, 0);
        checkPop("pt0", 0, 0, 1);
        accSum += step;
        applyStimulus(1, 4'h5, 1, 0);
        checkPop("pt1", 4'h3, 1, 1);
        accSum += step;
        applyStimulus(1, 4'hF, 1, 0);
        checkPop("pt2", 4'h5, 1, 1);
        accSum += step;
        applyStimulus(0, 0, 1, 0);
        checkPop("pt3", 4'hF, 1, 0);
        accSum += step;
        applyStimulus(0, 0, 1, 0);
        checkPop("pt4", 0, 0, 0);
        accSum += step;
        checkOutput("pt_acc_sum", {28'd0, accSum}, 7);

        // Fill, overflow (set beats clear), drain, then clear.
        for (int i = 1; i <= 4; i++) applyStimulus(1, 4'(i), 0, 0);
        checkOutput("fill_full", {31'd0, full}, 1);
        checkOutput("fill_in_ready", {31'd0, inReady}, 0);
        applyStimulus(1, 4'h9, 0, 1);
        checkOutput("ovf_set_priority", {31'd0, ovf}, 1);
        checkOutput("ovf_level", {29'd0, level}, 4);
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(0, 0, 1, 0);
            checkPop("drain", 4'(i), 1, 3'(4 - i));
        end
        applyStimulus(0, 0, 1, 0);
        checkPop("drain_empty", 0, 0, 0);
        checkOutput("ovf_sticky", {31'd0, ovf}, 1);
        applyStimulus(0, 0, 0, 1);
        checkOutput("ovf_cleared", {31'd0, ovf}, 0);

        // Full with simultaneous pop: pop proceeds, push is blocked.
        for (int i = 0; i < 4; i++) applyStimulus(1, 4'(i + 10), 0, 0);
        applyStimulus(1, 4'h7, 1, 0);
        checkPop("full_pop", 4'hA, 1, 3);
        checkOutput("full_pop_ovf", {31'd0, ovf}, 1);
        for (int i = 1; i < 4; i++) begin
            applyStimulus(0, 0, 1, 0);
            checkPop("full_drain", 4'(i + 10), 1, 3'(3 - i));
        end
        applyStimulus(0, 0, 0, 1);

        // Pointer wrap with continuous push and pop.
        applyStimulus(1, 4'd0, 1, 0);
        checkPop("wrap0", 0, 0, 1);
        for (int i = 1; i < 20; i++) begin
            applyStimulus(1, 4'(i), 1, 0);
            checkPop("wrap", 4'(i - 1), 1, 1);
        end
        applyStimulus(0, 0, 1, 0);
        checkPop("wrap_last", 4'd3, 1, 0);
        checkOutput("wrap_no_ovf", {31'd0, ovf}, 0);

        // Zero-valued entry, then a pop attempt while empty.
        applyStimulus(1, 4'd0, 0, 0);
        checkOutput("zero_level", {29'd0, level}, 1);
        applyStimulus(0, 0, 1, 0);
        checkPop("zero_pop", 0, 1, 0);
        applyStimulus(0, 0, 1, 0);
        checkPop("empty_pop", 0, 0, 0);

        applyStimulus(0, 0, 0, 0);
        compareOn = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/accum_step_fifo.md
# accum_step_fifo

Buffered feeder placed directly upstream of the 4-bit unsigned up accumulator. It accepts step values from a producer over a valid/ready handshake, stores up to DEPTH of them, and presents exactly one step per enabled cycle on `step`. When no step is due it presents zero, so the accumulator's unconditional `sum <= sum + step` becomes a no-op. The block also reports occupancy and a sticky overflow flag for producer protocol errors.

## Interface
- `WIDTH`, default 4: step width; must match the accumulator input width.
- `DEPTH`, default 4: FIFO entries; a power of two, ≥ 2.
- `AW`: derived, log2(DEPTH); not overridable.

Ports (name, direction, width, meaning):
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `clear_n`, in, 1: asynchronous, active-low reset.
- `in_valid`, in, 1: producer offers `in_data`.
- `in_data`, in, WIDTH: unsigned step value.
- `in_ready`, out, 1: equals `!full`; combinational from state.
- `pop_en`, in, 1: consumer permits a step this cycle.
- `step`, out, WIDTH: registered; drives the accumulator's addend input.
- `step_valid`, out, 1: registered; 1 when `step` carries a popped entry.
- `level`, out, AW+1: current occupancy, 0..DEPTH.
- `full`, out, 1: `level == DEPTH`.
- `empty`, out, 1: `level == 0`.
- `ovf`, out, 1: sticky flag; set by `in_valid && !in_ready`.
- `ovf_clr`, in, 1: synchronous clear of `ovf`.

## Operation
- Storage is a circular buffer with write pointer `wp` and read pointer `rp`, each AW+1 bits including a wrap bit.
  - `level = wp - rp` (mod 2^(AW+1)).
  - Pointers wrap naturally from DEPTH-1 to 0 in the index bits.
- Push occurs when `in_valid && in_ready`: `mem[wp] <= in_data`, `wp <= wp + 1`.
- Pop occurs when `pop_en && !empty`:
  - `step <= mem[rp]`, `step_valid <= 1`, `rp <= rp + 1`.
- When there is no pop: `step <= 0` and `step_valid <= 0`. A zero step must never leave the block otherwise.
- Zero-valued entries are legal data: they pop with `step_valid = 1` and `step = 0`.
- Simultaneous push and pop:
  - Both take effect.
  - `level` is unchanged when neither is blocked.
- Full:
  - `in_ready = 0` even if a pop happens in the same cycle; there is no full-bypass.
  - A push attempt while full is dropped, sets `ovf`, and leaves memory and `wp` untouched.
- Empty:
  - `pop_en` is ignored and `step` stays 0.
  - There is no write-through bypass, so an entry pushed at edge N cannot pop before edge N+1.
- `ovf`:
  - Set has priority over `ovf_clr` in the same cycle.
  - Cleared otherwise by `ovf_clr`.
- Reset (`clear_n = 0`, asynchronous, at any time including mid-burst):
  - `wp = rp = 0`, `step = 0`, `step_valid = 0`, `ovf = 0`.
  - Derived outputs: `level = 0`, `empty = 1`, `full = 0`, `in_ready = 1`.
  - Memory contents are not reset and are don't-care.
- No arithmetic is performed on data; values pass through unmodified, so accumulator wrap-around is the consumer's concern.

## Timing
- Push-to-storage: the entry is stored at the accepting edge. `level`, `full` and `empty` reflect it immediately after that edge.
- Pop latency: one cycle. `pop_en` sampled at edge N yields `step` and `step_valid` valid from edge N until edge N+1. The accumulator adds it at edge N+1.
- Minimum in-to-accumulator latency: push at edge N, pop at edge N+1, added at edge N+2.
- Throughput: one push and one pop per cycle, sustained when `level` is strictly between 0 and DEPTH.
- Reset release: the first push is accepted at the first rising edge after `clear_n` rises. Reset deassertion is assumed synchronised externally.

## Test plan
- **Reset:** assert `clear_n = 0` mid-stream with `level = 3`, then release. Required: `step = 0`, `step_valid = 0`, `level = 0`, `empty = 1`, `in_ready = 1`, `ovf = 0`.
- **Ordered pass-through:** push 3, 5, 0xF with `pop_en = 1` continuously.
  - Required: `step` sequence is 0, 3, 5, 0xF, 0 with `step_valid` 0, 1, 1, 1, 0.
  - Downstream accumulator sum is (3+5+15) mod 16 = 7.
- **Fill and overflow:** with `pop_en = 0`, push 1, 2, 3, 4, then offer 9.
  - Required: `full = 1`, `in_ready = 0`, 9 is dropped, `ovf = 1`.
  - After draining, pops are 1, 2, 3, 4.
  - `ovf_clr` then clears `ovf`.
- **Full with simultaneous pop:** at `level = 4`, assert `in_valid` with value 7 and `pop_en` together.
  - Required: the pop yields the head, the push is blocked, `ovf = 1`, `level = 3`.
- **Pointer wrap:** 20 cycles of continuous push and pop of incrementing values 0..19 (mod 16).
  - Required: `level` stays 1 after the first cycle, there are no drops, and `step` equals the pushed value one cycle later.
- **Zero data and empty pop:** push 0, then pop twice.
  - Required: the first pop gives `step = 0` with `step_valid = 1`.
  - The second pop gives `step = 0` with `step_valid = 0`, and `level` stays 0.
